// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready acceptance.
// DIRECT mode emits one strobe of PULSE cycles; SCAN mode walks the strobe
// from a start index up to the top output, then pulses scan_done.
module decoder_nto2n_seq #(
   parameter int N          = 3,
   parameter int PULSE      = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                mode,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in,
   output logic [(1<<N)-1:0]   out,
   output logic                out_valid,
   output logic                busy,
   output logic                scan_done
);

   localparam int W  = 1 << N;
   localparam int CW = $clog2(PULSE + 1);
   localparam logic [CW-1:0] RELOAD   = CW'(PULSE - 1);
   localparam logic [N-1:0]  TOP_IDX  = '1;
   localparam logic [W-1:0]  IDLE_OUT = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SCAN
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   out_q, out_d;
   logic           outValid_q, outValid_d;
   logic           scanDone_q, scanDone_d;
   logic [W-1:0]   selOneHot;

   // Acceptance is only possible from IDLE with the global enable high.
   always_comb begin
      in_ready = (state_q == ST_IDLE) && enable;
      busy     = (state_q != ST_IDLE);
   end

   // Next-state logic; outputs are derived from the next state so that the
   // strobe appears in the cycle right after the accepting edge.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      scanDone_d = 1'b0;
      selOneHot  = '0;
      case (state_q)
         ST_IDLE: begin
            if (enable && in_valid) begin
               idx_d   = in;
               cnt_d   = RELOAD;
               state_d = mode ? ST_SCAN : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SCAN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               if (idx_q == TOP_IDX) begin
                  state_d    = ST_IDLE;
                  scanDone_d = 1'b1;
               end else begin
                  idx_d = idx_q + N'(1);
                  cnt_d = RELOAD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d != ST_IDLE) begin
         selOneHot = W'(1) << idx_d;
      end
      out_d      = (ACTIVE_LOW != 0) ? ~selOneHot : selOneHot;
      outValid_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         out_q      <= IDLE_OUT;
         outValid_q <= 1'b0;
         scanDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         outValid_q <= outValid_d;
         scanDone_q <= scanDone_d;
      end
   end

   assign out       = out_q;
   assign out_valid = outValid_q;
   assign scan_done = scanDone_q;

endmodule
